// File: rtl/mul_unit.sv
// Iterative RV32M multiply unit: 32-cycle shift-add multiplier that holds its
// selected 32-bit result on the CDB request port until the arbiter grants it.
module mul_unit #(
    parameter int ROB_DEPTH = 8,
    localparam int TAG_W = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_q1,
    input  logic [31:0]      in_q2,
    input  logic [TAG_W-1:0] in_rob_dest,
    output logic             unit_ready,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_rob_entry,
    output logic [31:0]      cdb_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic        neg;
    logic        hi_half;

    logic        a_signed, b_signed;
    logic        a_neg, b_neg;
    logic [32:0] sum;
    logic [63:0] acc_next;
    logic [63:0] prod;
    logic        last_iter;

    // MULH treats both operands as signed, MULHSU only rs1; reserved codes act as MUL.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (in_funct3)
            3'd1: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2: a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed & in_q1[31];
    assign b_neg = b_signed & in_q2[31];

    // Add into the upper half with carry-out, then shift the whole accumulator right.
    assign sum       = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    assign acc_next  = 64'({sum, acc[31:0]} >> 1);
    assign prod      = neg ? (~acc_next + 64'd1) : acc_next;
    assign last_iter = (cnt == 6'd31);

    assign unit_ready = (state == IDLE) && !in_valid && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = BUSY;
                BUSY:    if (last_iter) state_next = DONE;
                DONE:    if (cdb_grant) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
            neg           <= 1'b0;
            hi_half       <= 1'b0;
            cdb_req       <= 1'b0;
            cdb_rd_data   <= '0;
            cdb_rob_entry <= '0;
        end else if (flush) begin
            cdb_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand         <= a_neg ? (~in_q1 + 32'd1) : in_q1;
                        mplier        <= b_neg ? (~in_q2 + 32'd1) : in_q2;
                        neg           <= a_neg ^ b_neg;
                        hi_half       <= (in_funct3 == 3'd1) || (in_funct3 == 3'd2)
                                      || (in_funct3 == 3'd3);
                        acc           <= '0;
                        cnt           <= '0;
                        cdb_rob_entry <= in_rob_dest;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (last_iter) begin
                        cdb_rd_data <= hi_half ? prod[63:32] : prod[31:0];
                        cdb_req     <= 1'b1;
                    end
                end
                DONE: begin
                    if (cdb_grant) cdb_req <= 1'b0;
                end
                default: cdb_req <= 1'b0;
            endcase
        end
    end

endmodule
